// File: rtl/cfoc_seq.sv
// cfoc_seq: packet-level sequencer for the CFOC datapath of the OFDM receiver.
// It arms on the coarse-sync packet-start pulse and waits for the CFOE estimate.
// It then latches the estimate and presents it on cfo_out/cfo_vld for the packet
// and for a short pipeline flush. Estimator timeout and re-arming are handled here.
// Optional feature: define CFOC_EST_LIMIT_EN to reject estimates whose magnitude
// exceeds EST_LIMIT while waiting for an estimate.
module cfoc_seq #(
    parameter int               EST_W     = 18,
    parameter int               TIMEOUT   = 2048,
    parameter int               MAX_LEN   = 16384,
    parameter int               FLUSH_LEN = 16,
    parameter logic [EST_W-1:0] EST_LIMIT = 18'd8192
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs_start,
    input  logic             din_vld,
    input  logic [EST_W-1:0] est_in,
    input  logic             est_vld,
    input  logic             pkt_end,
    output logic [EST_W-1:0] cfo_out,
    output logic             cfo_vld,
    output logic             busy,
    output logic [1:0]       state,
    output logic             timeout_err,
    output logic             est_rej
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_EST = 2'd1,
        CORRECT  = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] LEN_LAST     = 16'(MAX_LEN - 1);
    localparam logic [15:0] FLUSH_LAST   = 16'(FLUSH_LEN - 1);

    state_t           state_q;
    state_t           state_d;
    logic [15:0]      scnt_q;
    logic [15:0]      scnt_d;
    logic [EST_W-1:0] est_q;
    logic [EST_W-1:0] est_d;
    logic             timeout_d;
    logic             rej_d;
    logic             est_over;
    logic [EST_W-1:0] cfo_out_d;
    logic             cfo_vld_d;
    logic             busy_d;

`ifdef CFOC_EST_LIMIT_EN
    logic [EST_W:0] est_ext;
    logic [EST_W:0] est_mag;

    // Magnitude of the estimate, one bit wider so the most negative code negates cleanly
    always_comb begin
        est_ext  = {est_in[EST_W-1], est_in};
        est_mag  = est_in[EST_W-1] ? (~est_ext + 1'b1) : est_ext;
        est_over = (est_mag > {1'b0, EST_LIMIT});
    end
`else
    logic unused_limit;

    // Without the limit feature every estimate is acceptable; the limit value is only sunk
    always_comb begin
        est_over     = 1'b0;
        unused_limit = ^EST_LIMIT;
    end
`endif

    // Next-state, sample counter and estimate latch decisions
    always_comb begin
        state_d   = state_q;
        scnt_d    = scnt_q;
        est_d     = est_q;
        timeout_d = 1'b0;
        rej_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_start) begin
                    state_d = WAIT_EST;
                    scnt_d  = '0;
                end
            end
            WAIT_EST: begin
                if (est_vld && !est_over) begin
                    est_d   = est_in;
                    scnt_d  = '0;
                    state_d = CORRECT;
                end else if (est_vld) begin
                    rej_d = 1'b1;
                end else if (cs_start) begin
                    scnt_d = '0;
                end else if (din_vld) begin
                    if (scnt_q == TIMEOUT_LAST) begin
                        timeout_d = 1'b1;
                        scnt_d    = '0;
                        state_d   = IDLE;
                    end else begin
                        scnt_d = scnt_q + 16'd1;
                    end
                end
            end
            CORRECT: begin
                if (pkt_end || (din_vld && (scnt_q == LEN_LAST))) begin
                    scnt_d  = '0;
                    state_d = FLUSH;
                end else if (din_vld) begin
                    scnt_d = scnt_q + 16'd1;
                end
            end
            FLUSH: begin
                if (scnt_q == FLUSH_LAST) begin
                    scnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    scnt_d = scnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                scnt_d  = '0;
            end
        endcase
    end

    // Output values for the coming cycle, derived from where the FSM is heading
    always_comb begin
        cfo_vld_d = (state_d == CORRECT) || (state_d == FLUSH);
        cfo_out_d = cfo_vld_d ? est_d : '0;
        busy_d    = (state_d != IDLE);
    end

    // State, counter, estimate and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            scnt_q      <= '0;
            est_q       <= '0;
            cfo_out     <= '0;
            cfo_vld     <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            est_rej     <= 1'b0;
        end else begin
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            est_q       <= est_d;
            cfo_out     <= cfo_out_d;
            cfo_vld     <= cfo_vld_d;
            busy        <= busy_d;
            timeout_err <= timeout_d;
            est_rej     <= rej_d;
        end
    end

    assign state = state_q;

endmodule

// File: doc/cfoc_seq.md
# cfoc_seq

Packet-level sequencer for the CFOC datapath in the OFDM receiver. It arms on the coarse-sync packet-start pulse and waits for the CFOE estimate. It then latches that estimate and drives the CFOC `cfo_estimated`/`cfo_estimated_vld` pair for the packet's duration, and holds it through a pipeline flush. It also handles estimator timeout, re-arming and packet termination.

## Interface
- `EST_W`, 18: CFO estimate width (two's complement, CFOE/CFOC format).
- `TIMEOUT`, 2048: samples allowed between `cs_start` and estimate before abort.
- `MAX_LEN`, 16384: maximum corrected samples per packet.
- `FLUSH_LEN`, 16: cycles `cfo_vld` stays high after packet end (CFOC pipeline drain).
- `EST_LIMIT`, 18'd8192: magnitude limit used only with `CFOC_EST_LIMIT_EN`.
- `clk`  in  1  system clock (`CLK_PERIOD`).
- `rst`  in  1  asynchronous, active-low reset.
- `cs_start`  in  1  one-cycle packet-start pulse from coarse sync.
- `din_vld`  in  1  sample strobe, aligned with samples entering CFOC.
- `est_in`  in  EST_W  CFO estimate from CFOE.
- `est_vld`  in  1  one-cycle estimate-valid pulse.
- `pkt_end`  in  1  one-cycle end-of-packet pulse from downstream.
- `cfo_out`  out  EST_W  to CFOC `cfo_estimated`.
- `cfo_vld`  out  1  to CFOC `cfo_estimated_vld`.
- `busy`  out  1  high in any state except IDLE.
- `state`  out  2  IDLE=0, WAIT_EST=1, CORRECT=2, FLUSH=3.
- `timeout_err`  out  1  one-cycle pulse on estimator timeout.
- `est_rej`  out  1  one-cycle pulse on a rejected estimate (always 0 without the macro).

## Operation
- IDLE: `cs_start` goes to WAIT_EST and clears the sample counter `scnt`. `est_vld` and `pkt_end` are ignored.
- WAIT_EST:
  - `scnt` increments on each `din_vld`.
  - `est_vld` with an accepted estimate latches `est_in` into `est_q`, clears `scnt` and goes to CORRECT.
  - `scnt == TIMEOUT-1` with `din_vld` pulses `timeout_err` and goes to IDLE.
  - `cs_start` clears `scnt` and stays in WAIT_EST (re-arm).
  - If `est_vld` and `cs_start` arrive together, the estimate wins.
- CORRECT:
  - `cfo_vld`=1 and `cfo_out`=`est_q`.
  - `scnt` increments on `din_vld`.
  - `pkt_end`, or `din_vld` with `scnt == MAX_LEN-1`, goes to FLUSH and clears `scnt`.
  - `cs_start` and `est_vld` are ignored, so the estimate stays frozen for the packet.
- FLUSH:
  - `cfo_vld`=1 and `cfo_out`=`est_q`.
  - `scnt` counts every clock, not only `din_vld` cycles.
  - At `scnt == FLUSH_LEN-1`, go to IDLE.
  - `cs_start` here is dropped, not queued.
- In IDLE and WAIT_EST, `cfo_out`=0 and `cfo_vld`=0.
- `scnt` is 16 bits and never wraps; every terminal compare happens before overflow.
- Parameters need `TIMEOUT`, `MAX_LEN` and `FLUSH_LEN` ≥ 1 and ≤ 65535.

## Timing
- All outputs are registered.
- Reset values: `cfo_out`=0, `cfo_vld`=0, `busy`=0, `state`=0, `timeout_err`=0, `est_rej`=0, `est_q`=0, `scnt`=0.
- `est_vld` sampled at edge N gives `cfo_vld`=1 with the new `cfo_out` after edge N (one cycle of latency).
- `pkt_end` at edge N: FLUSH starts after edge N, and `cfo_vld` falls after edge N+FLUSH_LEN.
- `timeout_err` and `est_rej` go high the cycle after the triggering edge, for exactly one cycle.
- Reset asserted mid-packet clears everything immediately. After release the block is in IDLE and needs a fresh `cs_start`.

## Configuration
- `CFOC_EST_LIMIT_EN` defined: in WAIT_EST, an estimate with |`est_in`| > `EST_LIMIT` is rejected.
  - A rejected estimate pulses `est_rej` and leaves state and `scnt` unchanged, so the block keeps waiting.
  - The magnitude check uses sign-extended negation so that the most negative value does not overflow.
- Macro not defined: every `est_vld` in WAIT_EST is accepted, the limit logic is absent and `est_rej` is tied to 0.

## Test plan
- Nominal packet: `cs_start` at cycle 10, `est_vld` with 18'h3FFAC at cycle 600, `pkt_end` at cycle 4000, `din_vld`=1 throughout.
  - Required: `cfo_vld`=1 from cycle 601 with `cfo_out`=18'h3FFAC.
  - Required: `cfo_vld` falls 16 cycles after `pkt_end`, then `state` returns to 0.
- Timeout: `cs_start`, then no `est_vld` and constant `din_vld`. Required: `timeout_err` pulses 2048 samples later, `state` returns to 0 and `cfo_vld` never rises.
- Re-arm and collisions:
  - `cs_start` again at 1500 samples into WAIT_EST. Required: the timeout moves out to 2048 samples after the second pulse.
  - `cs_start` together with `est_vld`. Required: the block enters CORRECT.
- Frozen estimate and max length: in CORRECT, send a second `est_vld` with 18'h00100, then a `cs_start`, with no `pkt_end`.
  - Required: `cfo_out` stays 18'h3FFAC.
  - Required: FLUSH is entered after 16384 `din_vld` samples.
- Limit, with `CFOC_EST_LIMIT_EN` defined:
  - `est_in`=18'h02001 (8193). Required: `est_rej` pulses and the block stays in WAIT_EST.
  - Next `est_in`=18'h3E000 (-8192). Required: accepted, block goes to CORRECT.
  - Without the macro, 8193 is accepted.
- Reset mid-packet: drop `rst` low during CORRECT. Required: all outputs are 0 asynchronously, and after release `est_vld` without a `cs_start` is ignored.
